// File: rtl/riscv_mem_pkg.sv
// Shared constants and types for the instruction/data memory arbiter.
// Port ids tag each entry of the response tracker so a returning word goes to the right requester.
package riscv_mem_pkg;

  localparam int WORD_BYTES = 4;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef struct packed {
    logic       valid;
    logic       port;
    logic [1:0] offset;
  } rsp_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side fetch/load-store handshakes and the memory-side bus of the arbiter.
// The slave modport is the arbiter's view; master is the core plus memory environment.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 10
);

  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [31:0]           i_rdata;

  logic                  d_req;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [3:0]            d_we;
  logic [31:0]           d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [31:0]           d_rdata;
  logic                  d_err;

  logic [ADDR_WIDTH-1:0] mem_address;
  logic [3:0]            mem_write_en;
  logic [31:0]           mem_data_in;
  logic [31:0]           mem_data_out;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_we, d_wdata, mem_data_out,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
    output mem_address, mem_write_en, mem_data_in
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_we, d_wdata, mem_data_out,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_address, mem_write_en, mem_data_in
  );

endinterface

// File: rtl/lane_align.sv
// Combinational byte-lane steering: shifts store enables/data up to their lanes
// (flagging lanes pushed past the word) and right-justifies returning load data.
module lane_align
  import riscv_mem_pkg::*;
(
  input  logic [WORD_BYTES-1:0] st_we,
  input  logic [31:0]           st_wdata,
  input  logic [1:0]            st_offset,
  output logic [WORD_BYTES-1:0] mem_we,
  output logic [31:0]           mem_wdata,
  output logic                  overflow,
  input  logic [31:0]           ld_word,
  input  logic [1:0]            ld_offset,
  output logic [31:0]           ld_data
);

  logic [2*WORD_BYTES-2:0] we_wide;

  // Widen before shifting so enables that fall off the top can be detected.
  always_comb begin
    we_wide   = {{(WORD_BYTES-1){1'b0}}, st_we} << st_offset;
    mem_we    = we_wide[WORD_BYTES-1:0];
    overflow  = |we_wide[2*WORD_BYTES-2:WORD_BYTES];
    mem_wdata = st_wdata << {st_offset, 3'b000};
    ld_data   = ld_word >> {ld_offset, 3'b000};
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory between instruction fetch and load/store;
// data wins unless fetch has waited MAX_DATA_BURST consecutive data grants.
module mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int MAX_DATA_BURST = 2
) (
  input logic         clock,
  input logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_DATA_BURST);

  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  rsp_t          rsp_q, rsp_d;
  logic          d_err_q, d_err_d;

  logic        i_gnt, d_gnt, is_store;
  logic [3:0]  st_we;
  logic [31:0] st_wdata, ld_data;
  logic        overflow;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus.i_addr[1:0];

  lane_align u_lane_align (
    .st_we     (bus.d_we),
    .st_wdata  (bus.d_wdata),
    .st_offset (bus.d_addr[1:0]),
    .mem_we    (st_we),
    .mem_wdata (st_wdata),
    .overflow  (overflow),
    .ld_word   (bus.mem_data_out),
    .ld_offset (rsp_q.offset),
    .ld_data   (ld_data)
  );

  // Grants are held off entirely while reset is asserted.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset) begin
      if (bus.i_req && (!bus.d_req || burst_cnt_q == BURST_MAX)) begin
        i_gnt = 1'b1;
      end else if (bus.d_req) begin
        d_gnt = 1'b1;
      end
    end
    is_store = d_gnt && (|bus.d_we);
  end

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (!bus.i_req || i_gnt) begin
      burst_cnt_d = '0;
    end else if (d_gnt && burst_cnt_q != BURST_MAX) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end

    rsp_d.valid  = i_gnt || (d_gnt && !is_store);
    rsp_d.port   = d_gnt ? PORT_D : PORT_I;
    rsp_d.offset = d_gnt ? bus.d_addr[1:0] : 2'b00;

    d_err_d = is_store && overflow;
  end

  always_comb begin
    bus.i_gnt        = i_gnt;
    bus.d_gnt        = d_gnt;
    bus.mem_address  = '0;
    bus.mem_write_en = '0;
    bus.mem_data_in  = '0;
    if (i_gnt) begin
      bus.mem_address = {bus.i_addr[ADDR_WIDTH-1:2], 2'b00};
    end else if (d_gnt) begin
      bus.mem_address  = {bus.d_addr[ADDR_WIDTH-1:2], 2'b00};
      bus.mem_write_en = st_we;
      bus.mem_data_in  = st_wdata;
    end
  end

  // Memory data is steered to whichever port the tracker says issued last cycle.
  always_comb begin
    bus.i_rvalid = rsp_q.valid && (rsp_q.port == PORT_I);
    bus.d_rvalid = rsp_q.valid && (rsp_q.port == PORT_D);
    bus.i_rdata  = bus.i_rvalid ? bus.mem_data_out : 32'h0;
    bus.d_rdata  = bus.d_rvalid ? ld_data : 32'h0;
    bus.d_err    = d_err_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      burst_cnt_q <= '0;
      rsp_q       <= '0;
      d_err_q     <= 1'b0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      rsp_q       <= rsp_d;
      d_err_q     <= d_err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small byte-lane synchronous memory model;
// expected values are hand-computed from the preloaded words.
module tb_mem_arbiter;

  logic clock;
  logic reset;

  int check_count;
  int error_count;

  logic [31:0] mem [0:255];

  mem_arbiter_if #(.ADDR_WIDTH(10)) bus ();

  mem_arbiter #(
    .ADDR_WIDTH     (10),
    .MAX_DATA_BURST (2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory contents are (re)loaded while reset is held low.
  always @(posedge clock) begin
    if (!reset) begin
      for (int w = 0; w < 256; w++) mem[w] <= 32'h0;
      mem[0] <= 32'h00000513;
      mem[1] <= 32'h06800593;
      mem[2] <= 32'h00b50023;
      mem[3] <= 32'h0000006f;
      mem[4] <= 32'h44332211;
      mem[8] <= 32'hDEADBEEF;
      bus.mem_data_out <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_write_en[b]) mem[bus.mem_address[9:2]][8*b +: 8] <= bus.mem_data_in[8*b +: 8];
      end
      bus.mem_data_out <= mem[bus.mem_address[9:2]];
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic ir, input logic [9:0] ia, input logic dr,
                                input logic [9:0] da, input logic [3:0] dwe, input logic [31:0] dwd);
    @(posedge clock);
    #1;
    bus.i_req   = ir;
    bus.i_addr  = ia;
    bus.d_req   = dr;
    bus.d_addr  = da;
    bus.d_we    = dwe;
    bus.d_wdata = dwd;
    @(negedge clock);
  endtask

  task automatic set_idle();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_addr  = '0;
    bus.d_we    = '0;
    bus.d_wdata = '0;
  endtask

  initial begin
    logic [5:0] exp_d_seq;
    logic       prev_d;
    check_count = 0;
    error_count = 0;
    exp_d_seq   = 6'b011011;
    prev_d      = 1'b0;

    // Requests are asserted during reset to show nothing leaks through.
    reset       = 1'b0;
    bus.i_req   = 1'b1;
    bus.i_addr  = 10'h3FC;
    bus.d_req   = 1'b1;
    bus.d_addr  = 10'h3FF;
    bus.d_we    = 4'hF;
    bus.d_wdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_output("rst_i_gnt", bus.i_gnt, 0);
    check_output("rst_d_gnt", bus.d_gnt, 0);
    check_output("rst_mem_address", bus.mem_address, 0);
    check_output("rst_mem_write_en", bus.mem_write_en, 0);
    check_output("rst_mem_data_in", bus.mem_data_in, 0);
    check_output("rst_i_rvalid", bus.i_rvalid, 0);
    check_output("rst_d_rvalid", bus.d_rvalid, 0);
    check_output("rst_d_err", bus.d_err, 0);
    set_idle();
    reset = 1'b1;

    apply_stimulus(1, 10'h000, 0, 0, 0, 0);
    check_output("f0_i_gnt", bus.i_gnt, 1);
    check_output("f0_d_gnt", bus.d_gnt, 0);
    check_output("f0_mem_address", bus.mem_address, 10'h000);
    check_output("f0_mem_write_en", bus.mem_write_en, 0);
    apply_stimulus(1, 10'h004, 0, 0, 0, 0);
    check_output("f1_i_gnt", bus.i_gnt, 1);
    check_output("f1_mem_address", bus.mem_address, 10'h004);
    check_output("f1_i_rvalid", bus.i_rvalid, 1);
    check_output("f1_i_rdata", bus.i_rdata, 32'h00000513);
    apply_stimulus(1, 10'h00A, 0, 0, 0, 0);
    check_output("f2_mem_address", bus.mem_address, 10'h008);
    check_output("f2_i_rdata", bus.i_rdata, 32'h06800593);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("f3_i_gnt", bus.i_gnt, 0);
    check_output("f3_mem_address", bus.mem_address, 0);
    check_output("f3_i_rvalid", bus.i_rvalid, 1);
    check_output("f3_i_rdata", bus.i_rdata, 32'h00b50023);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("f4_i_rvalid", bus.i_rvalid, 0);
    check_output("f4_i_rdata", bus.i_rdata, 0);

    // Both ports requesting every cycle: D,D,I,D,D,I.
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(1, 10'h00C, 1, 10'h010, 0, 0);
      check_output($sformatf("cont%0d_d_gnt", k), bus.d_gnt, exp_d_seq[k]);
      check_output($sformatf("cont%0d_i_gnt", k), bus.i_gnt, !exp_d_seq[k]);
      if (k == 0) begin
        check_output("cont0_d_rvalid", bus.d_rvalid, 0);
        check_output("cont0_i_rvalid", bus.i_rvalid, 0);
      end else begin
        check_output($sformatf("cont%0d_d_rvalid", k), bus.d_rvalid, prev_d);
        check_output($sformatf("cont%0d_i_rvalid", k), bus.i_rvalid, !prev_d);
        check_output($sformatf("cont%0d_rdata", k), prev_d ? bus.d_rdata : bus.i_rdata,
                     prev_d ? 32'h44332211 : 32'h0000006f);
      end
      prev_d = exp_d_seq[k];
    end
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("cont_end_i_rvalid", bus.i_rvalid, 1);
    check_output("cont_end_i_rdata", bus.i_rdata, 32'h0000006f);
    check_output("cont_end_d_rvalid", bus.d_rvalid, 0);

    apply_stimulus(0, 0, 1, 10'h011, 0, 0);
    check_output("mis_d_gnt", bus.d_gnt, 1);
    check_output("mis_mem_address", bus.mem_address, 10'h010);
    check_output("mis_mem_write_en", bus.mem_write_en, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("mis_d_rvalid", bus.d_rvalid, 1);
    check_output("mis_d_rdata", bus.d_rdata, 32'h00443322);
    check_output("mis_i_rvalid", bus.i_rvalid, 0);

    apply_stimulus(0, 0, 1, 10'h013, 4'b0001, 32'h000000AB);
    check_output("sb_d_gnt", bus.d_gnt, 1);
    check_output("sb_mem_address", bus.mem_address, 10'h010);
    check_output("sb_mem_write_en", bus.mem_write_en, 4'b1000);
    check_output("sb_mem_data_in", bus.mem_data_in, 32'hAB000000);
    apply_stimulus(0, 0, 1, 10'h010, 0, 0);
    check_output("sb_ld_d_gnt", bus.d_gnt, 1);
    check_output("sb_no_rvalid", bus.d_rvalid, 0);
    check_output("sb_no_err", bus.d_err, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("sb_ld_d_rvalid", bus.d_rvalid, 1);
    check_output("sb_ld_d_rdata", bus.d_rdata, 32'hAB332211);

    apply_stimulus(0, 0, 1, 10'h022, 4'b1111, 32'h11223344);
    check_output("ovf_mem_address", bus.mem_address, 10'h020);
    check_output("ovf_mem_write_en", bus.mem_write_en, 4'b1100);
    check_output("ovf_mem_data_in", bus.mem_data_in, 32'h33440000);
    check_output("ovf_err_early", bus.d_err, 0);
    apply_stimulus(0, 0, 1, 10'h020, 0, 0);
    check_output("ovf_err_pulse", bus.d_err, 1);
    check_output("ovf_no_rvalid", bus.d_rvalid, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("ovf_err_clear", bus.d_err, 0);
    check_output("ovf_ld_d_rvalid", bus.d_rvalid, 1);
    check_output("ovf_ld_d_rdata", bus.d_rdata, 32'h3344BEEF);

    // Reset lands right after a load grant, so its response must vanish.
    apply_stimulus(0, 0, 1, 10'h010, 0, 0);
    check_output("mr_d_gnt", bus.d_gnt, 1);
    @(posedge clock);
    #1;
    reset     = 1'b0;
    bus.i_req = 1'b1;
    @(negedge clock);
    check_output("mr_d_rvalid", bus.d_rvalid, 0);
    check_output("mr_d_rdata", bus.d_rdata, 0);
    check_output("mr_d_gnt_held", bus.d_gnt, 0);
    check_output("mr_i_gnt_held", bus.i_gnt, 0);
    check_output("mr_mem_address", bus.mem_address, 0);
    @(negedge clock);
    check_output("mr_d_rvalid_still", bus.d_rvalid, 0);
    check_output("mr_i_rvalid_still", bus.i_rvalid, 0);
    set_idle();
    reset = 1'b1;
    apply_stimulus(0, 0, 1, 10'h010, 0, 0);
    check_output("post_rst_d_gnt", bus.d_gnt, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("post_rst_d_rvalid", bus.d_rvalid, 1);
    check_output("post_rst_d_rdata", bus.d_rdata, 32'h44332211);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single-ported, byte-lane 32-bit program/data memory between the RISC-V core's instruction-fetch port and its load/store port. One memory access per clock; the data port has priority, bounded by a starvation counter that guarantees fetch progress. The block aligns store byte-enables and write data to lanes, and right-justifies load data. It sits between the core and the `Memory` instance in the testbench and, later, the top level.

## Interface
- `ADDR_WIDTH`, 10, byte address width of both requesters and memory
- `MAX_DATA_BURST`, 2, consecutive data grants allowed while fetch is waiting (≥1)
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `i_req`  in  1  fetch request; held with `i_addr` until `i_gnt`
- `i_addr`  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
- `i_gnt`  out  1  fetch accepted this cycle
- `i_rvalid`  out  1  fetch data valid
- `i_rdata`  out  32  fetched word
- `d_req`  in  1  load/store request; held with operands until `d_gnt`
- `d_addr`  in  ADDR_WIDTH  data byte address
- `d_we`  in  4  store byte enables, right-justified (0 = load)
- `d_wdata`  in  32  store data, right-justified
- `d_gnt`  out  1  data request accepted this cycle
- `d_rvalid`  out  1  load data valid (loads only)
- `d_rdata`  out  32  load word shifted right by 8·`d_addr[1:0]`
- `d_err`  out  1  store lanes overflowed the word (pulse)
- `mem_address`  out  ADDR_WIDTH  to memory, bits [1:0] forced 0
- `mem_write_en`  out  4  to memory byte write enables
- `mem_data_in`  out  32  to memory write data
- `mem_data_out`  in  32  from memory; synchronous read, valid one cycle after address

## Operation
- Grant decision combinational each cycle. Exactly one of `i_gnt`/`d_gnt` high when any request present; none otherwise.
- Priority: `d_req` wins unless `i_req` && `burst_cnt == MAX_DATA_BURST`, then fetch wins.
- `burst_cnt`: +1 on `d_gnt` while `i_req` high (saturates at MAX_DATA_BURST); cleared on `i_gnt` or any cycle `i_req` low.
- Fetch grant: `mem_address = {i_addr[AW-1:2],2'b00}`, `mem_write_en = 0`.
- Data grant: `mem_address = {d_addr[AW-1:2],2'b00}`; `mem_write_en = (d_we << d_addr[1:0])[3:0]`; `mem_data_in = d_wdata << 8·d_addr[1:0]` (truncated to 32).
- Overflow: if `(d_we << d_addr[1:0])` has any bit above 3, the dropped lanes are not written and `d_err` pulses.
- No grant: `mem_address = 0`, `mem_write_en = 0`, `mem_data_in = 0`.
- Response tracker register: {valid, port, offset[1:0]} captured on each load/fetch grant; stores do not set valid.

## Timing
- Grant at cycle N → `*_rvalid` high for exactly cycle N+1, data from `mem_data_out`. Back-to-back grants give back-to-back responses, with no bubbles.
- `i_rdata = mem_data_out`; `d_rdata = mem_data_out >> 8·offset`. Both are 0 when the matching rvalid is low.
- `d_err` is registered and high in cycle N+1 of the offending store.
- Store commits at the rising edge ending cycle N. A load of the same word granted in N+1 returns the new data.
- Reset asserted (low): tracker, `burst_cnt`, `d_err`, all rvalids go to 0 immediately. Outstanding responses are dropped. All grant and memory outputs are 0 while in reset.
- First grant is possible in the first cycle after reset deasserts.

## Structure
- Package `riscv_mem_pkg`: `WORD_BYTES=4`, port-id constants `PORT_I=0`/`PORT_D=1`, and the response-tracker struct type.
- One sub-module `lane_align`: store enable/data shift with overflow flag, plus load right-shift. It is combinational and instantiated once.

## Test plan
- Fetch only: `i_req` at 0x000, 0x004, 0x008 on consecutive cycles → `i_gnt` each cycle, `i_rvalid` next cycles with the words preloaded from hello.hex.
- Contention: both requesting continuously, MAX_DATA_BURST=2 → grant order D,D,I,D,D,I; `burst_cnt` never exceeds 2.
- Byte store: `d_we=4'b0001`, `d_addr=0x013`, `d_wdata=0x000000AB` → `mem_write_en=4'b1000`, `mem_data_in=0xAB000000`. A later load of 0x010 returns 0xAB in byte 3.
- Overflow: `d_we=4'b1111` at 0x022 → `mem_write_en=4'b1100`, `d_err=1` in the next cycle only.
- Misaligned load at 0x011 of word 0x44332211 → `d_rdata=0x00443322`.
- Reset asserted in the cycle after a load grant → no `d_rvalid`; all outputs 0 until release.
